// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and encodings for the core memory-port arbiter.
package cm0_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERR    = 2'd2
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Size 2'b11 has no legal encoding and is reported the same way as a misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory handshake signals of the arbiter, grouped as one bundle.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane logic for the data path: misalignment detect, byte enables,
// store replication and zero-extended load extraction.
module mem_lane_align
    import cm0_mem_pkg::*;
(
    input  logic [1:0]  wr_size_i,
    input  logic [1:0]  wr_off_i,
    input  logic [31:0] wr_data_i,
    input  logic [1:0]  rd_size_i,
    input  logic [1:0]  rd_off_i,
    input  logic [31:0] rd_word_i,
    output logic        misalign_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted_s;

    // Request side: lane enables and replicated store data for the access size.
    always_comb begin
        misalign_o = is_misaligned(wr_size_i, wr_off_i);
        be_o       = 4'b0000;
        wdata_o    = 32'h0000_0000;
        case (wr_size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << wr_off_i;
                wdata_o = {4{wr_data_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = wr_off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wr_data_i[15:0]}};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wr_data_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = wr_data_i;
            end
        endcase
    end

    // Response side: bring the addressed lanes down to bit 0 and zero-extend.
    always_comb begin
        shifted_s = rd_word_i >> {rd_off_i, 3'b000};
        case (rd_size_i)
            SZ_BYTE: rdata_o = {24'h00_0000, shifted_s[7:0]};
            SZ_HALF: rdata_o = {16'h0000, shifted_s[15:0]};
            SZ_WORD: rdata_o = shifted_s;
            default: rdata_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store:
// data-first arbitration with a fetch-starvation limit, one transaction at a time.
module mem_port_arbiter
    import cm0_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output logic              busy
);

    localparam logic [3:0]        RUN_MAX   = 4'(MAX_DATA_RUN);
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    arb_state_e        state_q;
    logic [3:0]        run_q;
    logic              owner_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic              d_rvalid_q;
    logic              d_err_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              fetch_force_s;
    logic              if_gnt_s;
    logic              d_gnt_s;
    logic              misalign_s;
    logic [3:0]        d_be_s;
    logic [DATA_W-1:0] d_wdata_s;
    logic [DATA_W-1:0] d_rdata_ext_s;

    mem_lane_align u_lane_align (
        .wr_size_i  (bus.d_size),
        .wr_off_i   (bus.d_addr[1:0]),
        .wr_data_i  (bus.d_wdata),
        .rd_size_i  (size_q),
        .rd_off_i   (off_q),
        .rd_word_i  (bus.mem_rdata),
        .misalign_o (misalign_s),
        .be_o       (d_be_s),
        .wdata_o    (d_wdata_s),
        .rdata_o    (d_rdata_ext_s)
    );

    // Grant selection; grants are suppressed while reset is held so every output reads 0.
    always_comb begin
        fetch_force_s = bus.if_req && (run_q == RUN_MAX);
        if_gnt_s      = 1'b0;
        d_gnt_s       = 1'b0;
        if (rst && (state_q == IDLE)) begin
            if (bus.d_req && !fetch_force_s) begin
                d_gnt_s = 1'b1;
            end else if (bus.if_req) begin
                if_gnt_s = 1'b1;
            end else begin
                d_gnt_s  = 1'b0;
                if_gnt_s = 1'b0;
            end
        end else begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end
    end

    // Transaction FSM, run counter and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            run_q       <= 4'd0;
            owner_q     <= OWN_IF;
            size_q      <= SZ_BYTE;
            off_q       <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= {DATA_W{1'b0}};
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= {DATA_W{1'b0}};
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= {DATA_W{1'b0}};
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!bus.if_req || if_gnt_s) begin
                        run_q <= 4'd0;
                    end else if (d_gnt_s && (run_q != RUN_MAX)) begin
                        run_q <= run_q + 4'd1;
                    end
                    if (d_gnt_s) begin
                        owner_q <= OWN_D;
                        size_q  <= bus.d_size;
                        off_q   <= bus.d_addr[1:0];
                        if (misalign_s) begin
                            state_q <= ERR;
                        end else begin
                            state_q     <= ACCESS;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.d_we;
                            mem_addr_q  <= bus.d_addr & WORD_MASK;
                            mem_be_q    <= d_be_s;
                            mem_wdata_q <= d_wdata_s;
                        end
                    end else if (if_gnt_s) begin
                        owner_q     <= OWN_IF;
                        state_q     <= ACCESS;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr & WORD_MASK;
                        mem_be_q    <= 4'b1111;
                        mem_wdata_q <= {DATA_W{1'b0}};
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        if (owner_q == OWN_D) begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= mem_we_q ? {DATA_W{1'b0}} : d_rdata_ext_s;
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= bus.mem_rdata;
                        end
                    end
                end
                ERR: begin
                    state_q    <= IDLE;
                    d_rvalid_q <= 1'b1;
                    d_err_q    <= 1'b1;
                    d_rdata_q  <= {DATA_W{1'b0}};
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_gnt    = if_gnt_s;
    assign bus.d_gnt     = d_gnt_s;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = (state_q != IDLE);

endmodule
